// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage : instruction-fetch stage, producer side of the IF->ID interface.
//
// Owns the PC and keeps at most one instruction-memory request in flight.
// Each returned word is captured and presented to ID with its PC and PC+4.
// The stage also handles ID stalls through a one-entry skid buffer, EX branch
// redirects (flush), and stops fetching when a HALT opcode is fetched.
//
// Parameters
//   RESET_PC           PC loaded on reset
//   HALT_OPC           opcode (bits 31:26) that stops fetching
//
// Ports
//   clk                clock, all state on the rising edge
//   reset              asynchronous reset, active low
//   stall_f_id         ID cannot accept; hold all *_2_id outputs
//   branch_taken_f_ex  redirect / flush request from EX
//   branch_target_f_ex redirect PC, bits [1:0] are forced to zero
//   imem_req           instruction-memory request
//   imem_addr          request address, stable while imem_req is high
//   imem_rvalid        response valid (may come in the same cycle as req)
//   imem_rdata         instruction word
//   inst_2_id          instruction to ID, 32'h0 (NOP) when not valid
//   pc_out_2_id        PC of inst_2_id
//   pc4_out_2_id       PC+4 of inst_2_id
//   inst_valid_2_id    inst_2_id holds a real instruction
//   halted             fetch stopped on HALT
//
// Optional feature (macro IF_PERF_CNT_EN)
//   fetch_cnt          instructions loaded to the ID outputs (wraps)
//   flush_cnt          cycles with branch_taken_f_ex high (wraps)
// -----------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPC = 6'b010001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_f_id,
    input  logic        branch_taken_f_ex,
    input  logic [31:0] branch_target_f_ex,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_2_id,
    output logic [31:0] pc_out_2_id,
    output logic [31:0] pc4_out_2_id,
    output logic        inst_valid_2_id,
    output logic        halted
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_BUF,
        S_DROP,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pcOut_q, pcOut_d;
    logic [31:0] pc4Out_q, pc4Out_d;
    logic        valid_q, valid_d;
    logic [31:0] skid_q, skid_d;

    logic [31:0] pcPlus4;
    logic [31:0] loadWord;
    logic        loadEn;
    logic        outstanding;

    // pc+4 wraps naturally in 32 bits
    assign pcPlus4 = pc_q + 32'd4;

    // Registered outputs only; nothing here depends combinationally on inputs
    assign imem_req        = (state_q == S_FETCH);
    assign imem_addr       = pc_q;
    assign inst_2_id       = inst_q;
    assign pc_out_2_id     = pcOut_q;
    assign pc4_out_2_id    = pc4Out_q;
    assign inst_valid_2_id = valid_q;
    assign halted          = (state_q == S_HALT);

    // Next-state logic. A branch overrides everything else. Otherwise the
    // output register empties into a bubble whenever ID takes its word, and
    // is refilled in the same cycle from memory (S_FETCH) or the skid buffer
    // (S_BUF). The skid buffer's fullness is implied by being in S_BUF.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        pcOut_d     = pcOut_q;
        pc4Out_d    = pc4Out_q;
        valid_d     = valid_q;
        skid_d      = skid_q;
        loadWord    = imem_rdata;
        loadEn      = 1'b0;
        // A request is still owed a response if it has not returned this cycle
        outstanding = ((state_q == S_FETCH) || (state_q == S_DROP)) && !imem_rvalid;

        if (branch_taken_f_ex) begin
            valid_d = 1'b0;
            inst_d  = 32'h0;
            skid_d  = 32'h0;
            pc_d    = branch_target_f_ex & 32'hFFFF_FFFC;
            state_d = outstanding ? S_DROP : S_FETCH;
        end else begin
            if (!stall_f_id) begin
                valid_d = 1'b0;
                inst_d  = 32'h0;
            end

            case (state_q)
                S_IDLE: state_d = S_FETCH;
                S_FETCH: begin
                    if (imem_rvalid) begin
                        if (stall_f_id) begin
                            skid_d  = imem_rdata;
                            state_d = S_BUF;
                        end else begin
                            loadEn   = 1'b1;
                            loadWord = imem_rdata;
                        end
                    end
                end
                S_BUF: begin
                    if (!stall_f_id) begin
                        loadEn   = 1'b1;
                        loadWord = skid_q;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) begin
                        state_d = S_FETCH;
                    end
                end
                S_HALT: state_d = S_HALT;
                default: state_d = S_IDLE;
            endcase

            // The word that lands in the outputs always belongs to pc_q
            if (loadEn) begin
                inst_d   = loadWord;
                pcOut_d  = pc_q;
                pc4Out_d = pcPlus4;
                valid_d  = 1'b1;
                pc_d     = pcPlus4;
                state_d  = (loadWord[31:26] == HALT_OPC) ? S_HALT : S_FETCH;
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            inst_q   <= 32'h0;
            pcOut_q  <= 32'h0;
            pc4Out_q <= 32'h0;
            valid_q  <= 1'b0;
            skid_q   <= 32'h0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            pcOut_q  <= pcOut_d;
            pc4Out_q <= pc4Out_d;
            valid_q  <= valid_d;
            skid_q   <= skid_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetchCnt_q;
    logic [31:0] flushCnt_q;

    // Performance counters; loadEn is never set in a branch cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetchCnt_q <= 32'h0;
            flushCnt_q <= 32'h0;
        end else begin
            if (loadEn) begin
                fetchCnt_q <= fetchCnt_q + 32'd1;
            end
            if (branch_taken_f_ex) begin
                flushCnt_q <= flushCnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt = fetchCnt_q;
    assign flush_cnt = flushCnt_q;
`endif

endmodule
